// File: rtl/acc_pkg.sv
// acc_pkg: definitions shared by the accumulator feeder and the accumulator core.
//   - ACC_DATA_W / ACC_CNT_W : default data and beat-count widths
//   - acc_state_e            : feeder sequencing states
package acc_pkg;

  localparam int unsigned ACC_DATA_W = 8;
  localparam int unsigned ACC_CNT_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    SETTLE,
    DONE
  } acc_state_e;

endpackage

// File: rtl/acc_feeder_if.sv
// acc_feeder_if: bundles the command, accumulator and result signals of acc_feeder.
//   Command : cmd_valid, cmd_ready, cmd_step, cmd_count, cmd_clear
//   Accum   : acc_clr, acc_vaild, acc_in (to accumulator), acc_out (from accumulator)
//   Result  : res_valid, res_data, res_err, busy
// Modports:
//   slave  - the feeder itself (takes commands and acc_out, drives everything else)
//   master - the control/test side and accumulator surroundings
interface acc_feeder_if
  import acc_pkg::*;
#(
  parameter int unsigned DATA_W = ACC_DATA_W,
  parameter int unsigned CNT_W  = ACC_CNT_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_step;
  logic [CNT_W-1:0]  cmd_count;
  logic              cmd_clear;

  logic              acc_clr;
  logic              acc_vaild;
  logic [DATA_W-1:0] acc_in;
  logic [DATA_W-1:0] acc_out;

  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_err;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_step, cmd_count, cmd_clear, acc_out,
    output cmd_ready, acc_clr, acc_vaild, acc_in,
    output res_valid, res_data, res_err, busy
  );

  modport master (
    output cmd_valid, cmd_step, cmd_count, cmd_clear, acc_out,
    input  cmd_ready, acc_clr, acc_vaild, acc_in,
    input  res_valid, res_data, res_err, busy
  );

endinterface

// File: rtl/acc_feeder_cnt.sv
// acc_feeder_cnt: loadable beat down-counter for acc_feeder.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_load       : load i_load_val (takes priority over i_dec)
//   i_load_val   : beat count to load
//   i_dec        : decrement by one (one beat issued)
//   o_last       : count == 1, the current beat is the final one
//   o_zero       : count == 0
//   o_ofs        : ramp offset of the current beat (0-based beat index)
// Build option: ACC_FEEDER_RAMP_EN enables the ramp offset; otherwise o_ofs is 0.
module acc_feeder_cnt
  import acc_pkg::*;
#(
  parameter int unsigned CNT_W  = ACC_CNT_W,
  parameter int unsigned DATA_W = ACC_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [CNT_W-1:0]  i_load_val,
  input  logic              i_dec,
  output logic              o_last,
  output logic              o_zero,
  output logic [DATA_W-1:0] o_ofs
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_last = (r_count == CNT_W'(1));
  assign o_zero = (r_count == '0);

`ifdef ACC_FEEDER_RAMP_EN
  // Offset tracks beats already issued; wraps modulo 2^DATA_W like the data path.
  logic [DATA_W-1:0] r_ofs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ofs <= '0;
    end else if (i_load) begin
      r_ofs <= '0;
    end else if (i_dec) begin
      r_ofs <= r_ofs + DATA_W'(1);
    end
  end

  assign o_ofs = r_ofs;
`else
  assign o_ofs = '0;
`endif

endmodule

// File: rtl/acc_feeder.sv
// acc_feeder: drives bursts of beats into the accumulator and checks the result.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : acc_feeder_if.slave
//          cmd_*      command handshake (accepted on cmd_valid && cmd_ready)
//          acc_clr    one-cycle accumulator clear before a burst
//          acc_vaild  beat valid, acc_in beat data, acc_out accumulator value
//          res_valid  one-cycle result pulse; res_data/res_err held until next
//          busy       any state other than IDLE
// Build option: ACC_FEEDER_RAMP_EN makes beat i carry step+i instead of step.
module acc_feeder
  import acc_pkg::*;
#(
  parameter int unsigned DATA_W = ACC_DATA_W,
  parameter int unsigned CNT_W  = ACC_CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  acc_feeder_if.slave   bus
);

  acc_state_e        r_state;
  acc_state_e        w_next;
  logic [DATA_W-1:0] r_step;
  logic [DATA_W-1:0] r_expected;
  logic [DATA_W-1:0] r_res_data;
  logic              r_res_err;

  logic              w_accept;
  logic              w_last;
  logic              w_zero;
  logic [DATA_W-1:0] w_ofs;
  logic [DATA_W-1:0] w_beat;

  assign w_accept = bus.cmd_valid && (r_state == IDLE);
  assign w_beat   = r_step + w_ofs;

  acc_feeder_cnt #(
    .CNT_W  (CNT_W),
    .DATA_W (DATA_W)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst),
    .i_load     (w_accept),
    .i_load_val (bus.cmd_count),
    .i_dec      (r_state == RUN),
    .o_last     (w_last),
    .o_zero     (w_zero),
    .o_ofs      (w_ofs)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    bus.cmd_ready = 1'b0;
    bus.busy      = 1'b1;
    bus.acc_clr   = 1'b0;
    bus.acc_vaild = 1'b0;
    bus.acc_in    = '0;
    bus.res_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
        if (w_accept) begin
          if (bus.cmd_clear) begin
            w_next = CLEAR;
          end else if (bus.cmd_count != '0) begin
            w_next = RUN;
          end else begin
            w_next = SETTLE;
          end
        end
      end
      CLEAR: begin
        bus.acc_clr = 1'b1;
        w_next      = w_zero ? SETTLE : RUN;
      end
      RUN: begin
        bus.acc_vaild = 1'b1;
        bus.acc_in    = w_beat;
        if (w_last) begin
          w_next = SETTLE;
        end
      end
      SETTLE: begin
        w_next = DONE;
      end
      DONE: begin
        bus.res_valid = 1'b1;
        w_next        = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Result compare is done while capturing at the end of SETTLE so that
  // res_err is already valid in the DONE cycle alongside res_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step     <= '0;
      r_expected <= '0;
      r_res_data <= '0;
      r_res_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_step     <= bus.cmd_step;
            r_expected <= bus.cmd_clear ? '0 : bus.acc_out;
          end
        end
        CLEAR: begin
          r_expected <= '0;
        end
        RUN: begin
          r_expected <= r_expected + w_beat;
        end
        SETTLE: begin
          r_res_data <= bus.acc_out;
          r_res_err  <= (bus.acc_out != r_expected);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.res_data = r_res_data;
  assign bus.res_err  = r_res_err;

endmodule

// File: tb/tb_acc_feeder.sv
// tb_acc_feeder: directed self-checking bench for acc_feeder with a
// behavioural accumulator attached to the acc_* signals.
module tb_acc_feeder;
  import acc_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;

`ifdef ACC_FEEDER_RAMP_EN
  localparam logic [DW-1:0] E1  = 8'd81;   // 5..13
  localparam logic [DW-1:0] E3  = 8'd114;  // 81 + 10+11+12
  localparam logic [DW-1:0] E2  = 8'd149;  // 20..34 = 405 mod 256
  localparam logic [DW-1:0] E5A = 8'd26;   // 5+6+7+8
  localparam logic [DW-1:0] E5B = 8'd47;   // 26 + 10+11
  localparam logic [DW-1:0] E7  = 8'd10;   // 1+2+3+4
`else
  localparam logic [DW-1:0] E1  = 8'd45;   // 9*5
  localparam logic [DW-1:0] E3  = 8'd75;   // 45 + 3*10
  localparam logic [DW-1:0] E2  = 8'd44;   // 15*20 = 300 mod 256
  localparam logic [DW-1:0] E5A = 8'd20;   // 4*5
  localparam logic [DW-1:0] E5B = 8'd40;   // 20 + 2*10
  localparam logic [DW-1:0] E7  = 8'd4;    // 4*1
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acc_feeder_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  acc_feeder #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural accumulator, with an override used to corrupt acc_out.
  logic [DW-1:0] acc_q = '0;
  logic          force_en = 1'b0;
  logic [DW-1:0] force_val = '0;

  always @(posedge clk) begin
    if (bus.acc_clr) acc_q <= '0;
    else if (bus.acc_vaild) acc_q <= acc_q + bus.acc_in;
  end

  assign bus.acc_out = force_en ? force_val : acc_q;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ramp_ofs(input int i);
`ifdef ACC_FEEDER_RAMP_EN
    return DW'(i);
`else
    return DW'(0) & DW'(i);
`endif
  endfunction

  // Issue one command from a negedge and follow it to res_valid.
  task automatic run_cmd(input string tag, input logic [DW-1:0] step,
                         input logic [CW-1:0] cnt, input logic clr,
                         input logic [DW-1:0] exp_data, input logic exp_err,
                         input int exp_wait, input bit junk, input bit frc);
    int k, wait_c, first, last, beats, clrs, resk, data_bad, ready_busy;
    logic [DW-1:0] rdata;
    logic rerr;
    bit got;
    first = 0; last = 0; beats = 0; clrs = 0; resk = 0;
    data_bad = 0; ready_busy = 0; got = 1'b0; rdata = '0; rerr = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_step  = step;
    bus.cmd_count = cnt;
    bus.cmd_clear = clr;
    wait_c = 0;
    while (!bus.cmd_ready && wait_c < 50) begin
      @(negedge clk);
      wait_c++;
    end
    @(posedge clk);
    #1;
    if (junk) begin
      bus.cmd_step  = 8'd99;
      bus.cmd_count = 8'd7;
      bus.cmd_clear = 1'b1;
    end else begin
      bus.cmd_valid = 1'b0;
    end
    for (k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (bus.acc_clr) clrs++;
      if (bus.acc_vaild) begin
        if (beats == 0) first = k;
        last = k;
        if (bus.acc_in !== step + ramp_ofs(beats)) data_bad++;
        beats++;
      end
      if (bus.busy && bus.cmd_ready) ready_busy++;
      if (frc && cnt != '0 && beats == int'(cnt) && k == last + 1) begin
        force_en  = 1'b1;
        force_val = 8'hAA;
      end
      if (bus.res_valid) begin
        resk  = k;
        rdata = bus.res_data;
        rerr  = bus.res_err;
        got   = 1'b1;
        break;
      end
    end
    force_en      = 1'b0;
    bus.cmd_valid = 1'b0;
    chk({tag, ".wait"}, wait_c, exp_wait);
    chk({tag, ".got_res"}, got, 1);
    chk({tag, ".clr_pulses"}, clrs, clr);
    chk({tag, ".beats"}, beats, cnt);
    if (cnt != '0) begin
      chk({tag, ".first_beat"}, first, clr ? 2 : 1);
      chk({tag, ".span"}, last - first + 1, cnt);
      chk({tag, ".res_lat"}, resk, last + 2);
    end else begin
      chk({tag, ".res_lat"}, resk, clr ? 3 : 2);
    end
    chk({tag, ".beat_data"}, data_bad, 0);
    chk({tag, ".ready_busy"}, ready_busy, 0);
    chk({tag, ".res_data"}, rdata, exp_data);
    chk({tag, ".res_err"}, rerr, exp_err);
  endtask

  initial begin
    int seen, bad;
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_step  = '0;
    bus.cmd_count = '0;
    bus.cmd_clear = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.cmd_ready", bus.cmd_ready, 1);
    chk("rst.busy", bus.busy, 0);
    chk("rst.ctl", {bus.acc_clr, bus.acc_vaild, bus.res_valid, bus.res_err}, 0);
    chk("rst.acc_in", bus.acc_in, 0);
    chk("rst.res_data", bus.res_data, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_cmd("t1", 8'd5, 8'd9, 1'b1, E1, 1'b0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    run_cmd("t3a", 8'd10, 8'd3, 1'b0, E3, 1'b0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    run_cmd("t3b", 8'd1, 8'd1, 1'b0, 8'hAA, 1'b1, 0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("t3b.hold_data", bus.res_data, 8'hAA);
    chk("t3b.hold_err", bus.res_err, 1);
    chk("t3b.pulse_once", bus.res_valid, 0);

    run_cmd("t2", 8'd20, 8'd15, 1'b1, E2, 1'b0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    run_cmd("t4", 8'd7, 8'd0, 1'b1, 8'd0, 1'b0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    run_cmd("t5a", 8'd5, 8'd4, 1'b1, E5A, 1'b0, 0, 1'b1, 1'b0);
    run_cmd("t5b", 8'd10, 8'd2, 1'b0, E5B, 1'b0, 1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // Reset during beat 3 of 9.
    bus.cmd_valid = 1'b1;
    bus.cmd_step  = 8'd3;
    bus.cmd_count = 8'd9;
    bus.cmd_clear = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && seen < 3; k++) begin
      @(negedge clk);
      if (bus.acc_vaild) seen++;
    end
    chk("t6.beats_before_rst", seen, 3);
    rst = 1'b0;
    #1;
    chk("t6.acc_vaild", bus.acc_vaild, 0);
    chk("t6.acc_in", bus.acc_in, 0);
    chk("t6.busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.acc_vaild || bus.res_valid || !bus.cmd_ready) bad++;
    end
    chk("t6.quiet_after_rst", bad, 0);

    run_cmd("t7", 8'd1, 8'd4, 1'b1, E7, 1'b0, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
